// File: rtl/lane_pkg.sv
// Shared encodings and lane geometry helper for the lane mover.
package lane_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SLIDE_L = 2'd1,
        S_SLIDE_R = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    function automatic int unsigned lane_x(input int unsigned lane,
                                           input int unsigned xBase,
                                           input int unsigned pitch);
        return xBase + lane * pitch;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Registers a debounced key level and emits a one-cycle registered press pulse.
module key_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyIn,
    output logic Press
);

    logic keyPrev;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            keyPrev <= 1'b0;
            Press   <= 1'b0;
        end else begin
            keyPrev <= KeyIn;
            Press   <= KeyIn & ~keyPrev;
        end
    end

endmodule

// File: rtl/lane_mover.sv
// Moves the player sprite between lanes, sliding PosX by STEP_PX per Tick,
// with a one-deep buffered move request and edge-blocked Bump pulses.
module lane_mover
    import lane_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned START_LANE = 0,
    parameter int unsigned X_BASE     = 20,
    parameter int unsigned LANE_PITCH = 40,
    parameter int unsigned STEP_PX    = 8,
    parameter int unsigned XW         = 10,
    localparam int unsigned LW        = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LeftIn,
    input  logic          RightIn,
    input  logic          Tick,
    output logic [LW-1:0] Lane,
    output logic [LW-1:0] TargetLane,
    output logic [XW-1:0] PosX,
    output logic          Moving,
    output logic          Bump
);

    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
    localparam logic [LW-1:0] RST_LANE  = LW'(START_LANE);
    localparam logic [XW-1:0] RST_X     = XW'(lane_x(START_LANE, X_BASE, LANE_PITCH));

    if (LANE_PITCH % STEP_PX != 0) begin : gBadStep
        $error("lane_mover: LANE_PITCH must be a multiple of STEP_PX");
    end
    if (START_LANE >= NUM_LANES) begin : gBadStart
        $error("lane_mover: START_LANE must be below NUM_LANES");
    end

    state_t        state, stateNext;
    dir_t          pend, pendNext;
    dir_t          pressDir, effDir;
    logic          pressL, pressR;
    logic [LW-1:0] laneNext, tgtNext;
    logic [XW-1:0] posNext, posStep, tgtX;
    logic          movingNext, bumpNext, arrive, decide;

    key_edge uLeftEdge (
        .Clock (Clock),
        .Reset (Reset),
        .KeyIn (LeftIn),
        .Press (pressL)
    );

    key_edge uRightEdge (
        .Clock (Clock),
        .Reset (Reset),
        .KeyIn (RightIn),
        .Press (pressR)
    );

    // Simultaneous presses cancel each other out.
    assign pressDir = (pressL & ~pressR) ? DIR_L :
                      (pressR & ~pressL) ? DIR_R : DIR_NONE;

    // A fresh press overrides whatever is buffered, including on the arrival cycle.
    assign effDir  = (pressDir != DIR_NONE) ? pressDir : pend;
    assign tgtX    = XW'(lane_x(32'(TargetLane), X_BASE, LANE_PITCH));
    assign posStep = (state == S_SLIDE_L) ? PosX - XW'(STEP_PX) : PosX + XW'(STEP_PX);
    assign arrive  = (state != S_IDLE) && Tick && (posStep == tgtX);
    assign decide  = (state == S_IDLE) || arrive;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            pend       <= DIR_NONE;
            Lane       <= RST_LANE;
            TargetLane <= RST_LANE;
            PosX       <= RST_X;
            Moving     <= 1'b0;
            Bump       <= 1'b0;
        end else begin
            state      <= stateNext;
            pend       <= pendNext;
            Lane       <= laneNext;
            TargetLane <= tgtNext;
            PosX       <= posNext;
            Moving     <= movingNext;
            Bump       <= bumpNext;
        end
    end

    // In IDLE TargetLane equals Lane, so one decision path serves both
    // a fresh press and the consumption of a buffered request on arrival.
    always_comb begin
        stateNext = state;
        pendNext  = pend;
        laneNext  = Lane;
        tgtNext   = TargetLane;
        posNext   = PosX;
        bumpNext  = 1'b0;

        if (state != S_IDLE) begin
            pendNext = effDir;
            if (Tick) begin
                posNext = posStep;
            end
        end

        if (decide) begin
            laneNext  = TargetLane;
            tgtNext   = TargetLane;
            pendNext  = DIR_NONE;
            stateNext = S_IDLE;
            case (effDir)
                DIR_L: begin
                    if (TargetLane == '0) begin
                        bumpNext = 1'b1;
                    end else begin
                        tgtNext   = TargetLane - LW'(1);
                        stateNext = S_SLIDE_L;
                    end
                end
                DIR_R: begin
                    if (TargetLane == LAST_LANE) begin
                        bumpNext = 1'b1;
                    end else begin
                        tgtNext   = TargetLane + LW'(1);
                        stateNext = S_SLIDE_R;
                    end
                end
                default: ;
            endcase
        end

        movingNext = (stateNext != S_IDLE);
    end

endmodule

// File: tb/tb_lane_mover.sv
// Self-checking bench for lane_mover: hand-derived vector table, directed
// multi-cycle sequences and randomized keys against a lane/tick-count model.
module tb_lane_mover;

    localparam int N     = 4;
    localparam int START = 0;
    localparam int XB    = 20;
    localparam int PITCH = 40;
    localparam int STEP  = 8;
    localparam int XW    = 10;
    localparam int LW    = 2;
    localparam int TPS   = PITCH / STEP;

    logic          Clock, Reset, LeftIn, RightIn, Tick;
    logic [LW-1:0] Lane, TargetLane;
    logic [XW-1:0] PosX;
    logic          Moving, Bump;

    int checks;
    int errors;

    // Model: lane indices, ticks completed in the current slide, pending as -1/0/+1.
    int mPrevL, mPrevR, mPressL, mPressR;
    int mLane, mTgt, mDone, mMoving, mPend, mBump;

    typedef struct {
        logic l, r, t;
        int   lane, tgt, pos, mv, bump;
    } vec_t;
    vec_t vecs[$];

    lane_mover #(
        .NUM_LANES (N),
        .START_LANE(START),
        .X_BASE    (XB),
        .LANE_PITCH(PITCH),
        .STEP_PX   (STEP),
        .XW        (XW)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .LeftIn    (LeftIn),
        .RightIn   (RightIn),
        .Tick      (Tick),
        .Lane      (Lane),
        .TargetLane(TargetLane),
        .PosX      (PosX),
        .Moving    (Moving),
        .Bump      (Bump)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int laneX(input int l);
        return XB + l * PITCH;
    endfunction

    function automatic int mPos();
        return laneX(mLane) + (mTgt - mLane) * mDone * STEP;
    endfunction

    function automatic void model_reset();
        mPrevL = 0; mPrevR = 0; mPressL = 0; mPressR = 0;
        mLane = START; mTgt = START; mDone = 0;
        mMoving = 0; mPend = 0; mBump = 0;
    endfunction

    function automatic void try_move(input int dir);
        int nl;
        nl = mLane + dir;
        if (nl < 0 || nl >= N) begin
            mBump = 1;
        end else begin
            mTgt = nl;
            mMoving = 1;
            mDone = 0;
        end
    endfunction

    function automatic void model_step(input int l, input int r, input int t);
        int pl, pr, dir, eff;
        pl = mPressL;
        pr = mPressR;
        mPressL = (l != 0 && mPrevL == 0) ? 1 : 0;
        mPressR = (r != 0 && mPrevR == 0) ? 1 : 0;
        mPrevL = l;
        mPrevR = r;
        dir = (pl != 0 && pr == 0) ? -1 : (pr != 0 && pl == 0) ? 1 : 0;
        mBump = 0;
        if (mMoving == 0) begin
            if (dir != 0) try_move(dir);
        end else begin
            if (dir != 0) mPend = dir;
            if (t != 0) begin
                mDone++;
                if (mDone == TPS) begin
                    mLane = mTgt;
                    eff = mPend;
                    mPend = 0;
                    mMoving = 0;
                    mDone = 0;
                    if (eff != 0) try_move(eff);
                end
            end
        end
    endfunction

    task automatic cmp_model(input string tag);
        chk({tag, ".Lane"}, int'(Lane), mLane);
        chk({tag, ".TargetLane"}, int'(TargetLane), mTgt);
        chk({tag, ".PosX"}, int'(PosX), mPos());
        chk({tag, ".Moving"}, int'(Moving), mMoving);
        chk({tag, ".Bump"}, int'(Bump), mBump);
    endtask

    // One clock cycle with given inputs; model advances at the edge, compare at negedge.
    task automatic cycle(input logic l, input logic r, input logic t);
        LeftIn = l; RightIn = r; Tick = t;
        @(posedge Clock);
        model_step(int'(l), int'(r), int'(t));
        @(negedge Clock);
        cmp_model("model");
    endtask

    task automatic do_reset();
        Reset = 1'b0; LeftIn = 1'b0; RightIn = 1'b0; Tick = 1'b0;
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    function automatic void add(input logic l, input logic r, input logic t,
                                input int lane, input int tgt, input int pos,
                                input int mv, input int bump);
        vec_t v;
        v.l = l; v.r = r; v.t = t;
        v.lane = lane; v.tgt = tgt; v.pos = pos; v.mv = mv; v.bump = bump;
        vecs.push_back(v);
    endfunction

    initial begin
        int bumps;
        int sawLane3;
        logic rl, rr, rt;

        checks = 0;
        errors = 0;
        Reset = 1'b0; LeftIn = 1'b0; RightIn = 1'b0; Tick = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        chk("rst.Lane", int'(Lane), 0);
        chk("rst.TargetLane", int'(TargetLane), 0);
        chk("rst.PosX", int'(PosX), 20);
        chk("rst.Moving", int'(Moving), 0);
        chk("rst.Bump", int'(Bump), 0);
        Reset = 1'b1;

        //  l  r  t   lane tgt pos mv bump
        add(0, 0, 0,  0, 0,  20, 0, 0);
        add(0, 1, 0,  0, 0,  20, 0, 0);
        add(0, 1, 0,  0, 1,  20, 1, 0);
        add(0, 1, 1,  0, 1,  28, 1, 0);
        add(0, 1, 0,  0, 1,  28, 1, 0);
        add(0, 1, 1,  0, 1,  36, 1, 0);
        add(0, 1, 1,  0, 1,  44, 1, 0);
        add(0, 1, 1,  0, 1,  52, 1, 0);
        add(0, 0, 1,  1, 1,  60, 0, 0);
        add(1, 0, 0,  1, 1,  60, 0, 0);
        add(1, 0, 0,  1, 0,  60, 1, 0);
        add(0, 0, 1,  1, 0,  52, 1, 0);
        add(0, 0, 1,  1, 0,  44, 1, 0);
        add(0, 0, 1,  1, 0,  36, 1, 0);
        add(0, 0, 1,  1, 0,  28, 1, 0);
        add(0, 0, 1,  0, 0,  20, 0, 0);
        add(1, 0, 0,  0, 0,  20, 0, 0);
        add(1, 0, 0,  0, 0,  20, 0, 1);
        add(1, 0, 1,  0, 0,  20, 0, 0);
        add(0, 0, 0,  0, 0,  20, 0, 0);
        add(1, 1, 0,  0, 0,  20, 0, 0);
        add(1, 1, 1,  0, 0,  20, 0, 0);
        add(0, 0, 1,  0, 0,  20, 0, 0);

        foreach (vecs[i]) begin
            LeftIn = vecs[i].l; RightIn = vecs[i].r; Tick = vecs[i].t;
            @(posedge Clock);
            model_step(int'(vecs[i].l), int'(vecs[i].r), int'(vecs[i].t));
            @(negedge Clock);
            chk($sformatf("vec%0d.Lane", i), int'(Lane), vecs[i].lane);
            chk($sformatf("vec%0d.TargetLane", i), int'(TargetLane), vecs[i].tgt);
            chk($sformatf("vec%0d.PosX", i), int'(PosX), vecs[i].pos);
            chk($sformatf("vec%0d.Moving", i), int'(Moving), vecs[i].mv);
            chk($sformatf("vec%0d.Bump", i), int'(Bump), vecs[i].bump);
        end

        // Chained right moves 0 -> 1 -> 2 without Moving dropping.
        do_reset();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1);
            chk("chain.Moving", int'(Moving), 1);
            if (i == 1) begin
                chk("chain.mid.Lane", int'(Lane), 1);
                chk("chain.mid.PosX", int'(PosX), 60);
                chk("chain.mid.TargetLane", int'(TargetLane), 2);
            end
        end
        cycle(0, 0, 1);
        chk("chain.end.Lane", int'(Lane), 2);
        chk("chain.end.PosX", int'(PosX), 100);
        chk("chain.end.Moving", int'(Moving), 0);

        // 2 -> 3 with right then left buffered: latest wins, slides back to 2.
        sawLane3 = 0;
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1);
            if (Lane == 2'd3) sawLane3 = 1;
        end
        chk("latest.sawLane3", sawLane3, 1);
        chk("latest.Lane", int'(Lane), 2);
        chk("latest.PosX", int'(PosX), 100);
        chk("latest.Moving", int'(Moving), 0);

        // 2 -> 3 with right buffered: blocked on arrival, single Bump.
        bumps = 0;
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1);
            if (Bump) bumps++;
        end
        chk("edgepend.bumps", bumps, 1);
        chk("edgepend.Lane", int'(Lane), 3);
        chk("edgepend.PosX", int'(PosX), 140);
        chk("edgepend.Moving", int'(Moving), 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        chk("edge3.Bump", int'(Bump), 1);
        chk("edge3.PosX", int'(PosX), 140);
        cycle(0, 0, 0);
        chk("edge3.BumpOff", int'(Bump), 0);

        // Asynchronous reset in the middle of a slide.
        do_reset();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("midrst.before.PosX", int'(PosX), 44);
        Reset = 1'b0;
        #1;
        chk("midrst.Lane", int'(Lane), 0);
        chk("midrst.TargetLane", int'(TargetLane), 0);
        chk("midrst.PosX", int'(PosX), 20);
        chk("midrst.Moving", int'(Moving), 0);
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;

        // Randomized key levels and ticks against the model.
        rl = 1'b0; rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rl = ~rl;
            if ($urandom_range(0, 7) == 0) rr = ~rr;
            if ($urandom_range(0, 49) == 0) begin
                rl = 1'b1; rr = 1'b1;
            end
            rt = ($urandom_range(0, 2) == 0);
            cycle(rl, rr, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_mover.md
Name: lane_mover

Overview:
- Parametrised successor to the 4-position character FSM.
- Moves the player sprite between NUM_LANES horizontal lanes on debounced left/right key presses.
- Produces an animated pixel X coordinate: the sprite slides STEP_PX per frame tick instead of jumping.
- One move request is buffered during a slide. Blocked moves at the edges are flagged. Feeds the sprite renderer and the collision checker.

Parameters:
- NUM_LANES, 4: number of lanes, 2..16.
- START_LANE, 0: lane loaded on reset, < NUM_LANES.
- X_BASE, 20: pixel X of lane 0.
- LANE_PITCH, 40: pixel distance between adjacent lanes.
- STEP_PX, 8: pixels moved per Tick while sliding. LANE_PITCH % STEP_PX == 0 is required (checked at elaboration).
- XW, 10: width of PosX.
- LW, derived: $clog2(NUM_LANES), minimum 1.

Ports:
- Clock, input, 1: system clock.
- Reset, input, 1: asynchronous, active-low reset.
- LeftIn, input, 1: debounced left key level.
- RightIn, input, 1: debounced right key level.
- Tick, input, 1: one-cycle frame-rate pulse from the rate divider.
- Lane, output, LW: committed lane, updates on arrival.
- TargetLane, output, LW: lane being moved to; equals Lane when idle.
- PosX, output, XW: current sprite pixel X.
- Moving, output, 1: high while sliding.
- Bump, output, 1: one-cycle pulse when a move is blocked at an edge.

Behaviour:
- Reset (async, Reset=0):
  - Lane = TargetLane = START_LANE.
  - PosX = X_BASE + START_LANE*LANE_PITCH.
  - Moving = 0, Bump = 0.
  - Pending buffer cleared; edge-detect history registers cleared to 0.
  - Reset mid-slide abandons the slide and the pending request.
- Press detection: press = In & ~In_prev, registered per key. Holding a key gives exactly one press.
- LeftIn and RightIn pressing in the same cycle: both ignored, no Bump.
- FSM states:
  - IDLE: press-left and Lane==0 -> Bump, stay IDLE. Press-right and Lane==NUM_LANES-1 -> Bump, stay IDLE. Any other press -> SLIDE_L or SLIDE_R.
  - Entering a slide: TargetLane = Lane±1 and Moving=1 on the edge after the press cycle (1-cycle latency).
  - SLIDE_L / SLIDE_R: on each Tick, PosX -= STEP_PX (left) or += STEP_PX (right). Cycles without Tick hold PosX.
- Arrival: the Tick edge on which PosX reaches X_BASE + TargetLane*LANE_PITCH.
  - Lane <= TargetLane.
  - No pending request: go to IDLE, Moving <= 0.
  - Pending legal from the new Lane: consume it on the same edge, set the new TargetLane, stay sliding, Moving stays 1.
  - Pending illegal from the new Lane: Bump pulses, pending is dropped, go to IDLE.
- Pending buffer: 1 deep, holds a direction. A press during a slide writes it, and the latest press wins. A press on the arrival cycle itself counts as pending.
- Reversing mid-slide is not allowed; a reverse press is buffered like any other.
- A slide takes exactly LANE_PITCH/STEP_PX Ticks. PosX never overshoots and never leaves [X_BASE, X_BASE+(NUM_LANES-1)*LANE_PITCH].
- Bump is high for exactly one cycle per blocked press.
- Lane and TargetLane always stay < NUM_LANES.

Decomposition:
- Shared package lane_pkg:
  - state encoding localparams S_IDLE, S_SLIDE_L, S_SLIDE_R;
  - direction encoding DIR_NONE, DIR_L, DIR_R;
  - function lane_x(lane) returning X_BASE + lane*LANE_PITCH.
- Sub-module key_edge: registers one key level and outputs a one-cycle press pulse. Instantiated twice.

Test Plan:
Defaults throughout: lanes at X = 20, 60, 100, 140; 5 Ticks per slide.
- Reset release, no keys -> Lane=0, TargetLane=0, PosX=20, Moving=0, Bump=0. Assert Reset for one cycle mid-slide at PosX=44 -> immediately Lane=0, PosX=20, Moving=0.
- Right press (level held 100 cycles), Tick every 4 cycles -> Moving=1 and TargetLane=1 one cycle after the press. PosX steps 28, 36, 44, 52, 60. Lane=1 on the 5th Tick, Moving=0. Only one move despite the held key.
- In lane 0, press left -> Bump high exactly one cycle, PosX stays 20. In lane 3, press right -> Bump pulse, PosX stays 140.
- From lane 0, press right, then press right again at PosX=36 -> continuous slide to lane 2. Moving never drops. Lane goes 1 at PosX=60, then 2 at PosX=100.
- During a 2->3 slide, press right, then left -> pending=left (latest wins). On arrival Lane=3, then slides back to lane 2, PosX=100.
- During a 2->3 slide, press right only -> on arrival Lane=3, Bump pulses, pending dropped, Moving=0, PosX=140. LeftIn and RightIn rising in the same cycle in IDLE -> no movement, no Bump.
